burst_mem_responder: RTL and testbench

Memory-side responder for the 32-byte-line burst read protocol issued by the instruction cache miss path. It accepts one aligned read request at a time and waits a programmable latency. It then streams 8 consecutive 32-bit words from an internal word RAM with per-beat valid/ready backpressure and a `last` flag on beat 8. It sits at the memory end of the cache refill interface and serves as the simulation/FPGA main-memory model. A preload write port fills the RAM before or between bursts.

---
 rtl/burst_mem_responder_pkg.sv | 23 ++
 rtl/burst_mem_responder_mem_word_array.sv | 26 ++
 rtl/burst_mem_responder.sv | 127 ++++++++++++
 tb/tb_burst_mem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_mem_responder_pkg.sv
// Shared constants and state encoding for the burst read memory responder.
package burst_mem_responder_pkg;

   localparam int unsigned BURST_LEN  = 8;
   localparam int unsigned LINE_BYTES = 32;
   localparam int unsigned WORD_BYTES = 4;

   localparam int unsigned BEAT_W     = $clog2(BURST_LEN);
   localparam int unsigned LAT_W      = 4;
   localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);
   localparam int unsigned LINE_SHIFT = $clog2(LINE_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_WAIT = 3'b010,
      ST_SEND = 3'b100
   } state_e;

   function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
      return beat == BEAT_W'(BURST_LEN - 1);
   endfunction

endpackage

// File: rtl/burst_mem_responder_mem_word_array.sv
// Word RAM: one synchronous write port, one asynchronous read port.
module mem_word_array #(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Commit one word per enabled cycle; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for 32-byte line burst reads: accepts one aligned
// request, waits LATENCY cycles, then streams 8 words with valid/ready.
module burst_mem_responder
   import burst_mem_responder_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 4096,
   parameter int unsigned LATENCY   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rd_req_valid,
   input  logic [31:0] mem_rd_req_addr,
   output logic        mem_rd_req_ready,
   output logic        mem_rd_rsp_valid,
   output logic [31:0] mem_rd_rsp_data,
   output logic        mem_rd_rsp_last,
   input  logic        mem_rd_rsp_ready,
   input  logic        init_wen,
   input  logic [31:0] init_addr,
   input  logic [31:0] init_data
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned LW = AW - BEAT_W;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY);

   state_e            state_q;
   logic [BEAT_W-1:0] beat_q;
   logic [BEAT_W-1:0] beat_d;
   logic [LAT_W-1:0]  lat_q;
   logic [LW-1:0]     line_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              rsp_last_q;

   logic              ram_we;
   logic [AW-1:0]     ram_waddr;
   logic [AW-1:0]     ram_raddr;
   logic [31:0]       ram_rdata;
   logic              unused_addr_bits;

   // Address bits outside the word index are deliberately ignored (aliasing).
   assign unused_addr_bits = ^{mem_rd_req_addr, init_addr};

   assign beat_d    = beat_q + BEAT_W'(1);
   assign ram_we    = init_wen && (state_q == ST_IDLE) && !rst;
   assign ram_waddr = init_addr[AW+WORD_SHIFT-1:WORD_SHIFT];
   // Line base is 8-word aligned, so base + beat is a plain concatenation.
   assign ram_raddr = {line_q, beat_q};

   mem_word_array #(
      .DEPTH (MEM_WORDS),
      .WIDTH (32)
   ) u_mem_word_array (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (init_data),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   // Request/latency/beat sequencing with handshake outputs registered alongside state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         lat_q       <= '0;
         line_q      <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mem_rd_req_valid) begin
                  line_q      <= mem_rd_req_addr[AW+WORD_SHIFT-1:LINE_SHIFT];
                  beat_q      <= '0;
                  lat_q       <= LAT_INIT;
                  req_ready_q <= 1'b0;
                  rsp_last_q  <= 1'b0;
                  if (LATENCY == 0) begin
                     state_q     <= ST_SEND;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               lat_q <= lat_q - LAT_W'(1);
               if (lat_q == LAT_W'(1)) begin
                  state_q     <= ST_SEND;
                  rsp_valid_q <= 1'b1;
               end
            end
            ST_SEND: begin
               if (mem_rd_rsp_ready) begin
                  beat_q <= beat_d;
                  if (is_last_beat(beat_q)) begin
                     state_q     <= ST_IDLE;
                     req_ready_q <= 1'b1;
                     rsp_valid_q <= 1'b0;
                     rsp_last_q  <= 1'b0;
                  end else begin
                     rsp_last_q <= is_last_beat(beat_d);
                  end
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               beat_q      <= '0;
               lat_q       <= '0;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_rd_req_ready = req_ready_q;
   assign mem_rd_rsp_valid = rsp_valid_q;
   assign mem_rd_rsp_last  = rsp_last_q;
   assign mem_rd_rsp_data  = rsp_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: two instances (LATENCY 4 and 0) checked by a
// scoreboard fed from a word-array reference model of the memory.
module tb_burst_mem_responder;

   localparam int MEMW = 4096;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        req_valid [2];
   logic [31:0] req_addr  [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_data  [2];
   logic        rsp_last  [2];
   logic        rsp_ready [2];
   logic        init_wen  [2];
   logic [31:0] init_addr [2];
   logic [31:0] init_data [2];

   int cmp_cnt = 0;
   int err_cnt = 0;
   int tmo_cnt = 0;
   bit done    = 1'b0;

   logic [32:0] exp0_q [$];
   logic [32:0] exp1_q [$];
   logic [31:0] model_mem [2][MEMW];
   bit          m_busy [2];
   int          m_wait [2];

   always #5 clk = ~clk;

   burst_mem_responder #(.MEM_WORDS(4096), .LATENCY(4)) u_dut_l4 (
      .clk(clk), .rst(rst[0]),
      .mem_rd_req_valid(req_valid[0]), .mem_rd_req_addr(req_addr[0]), .mem_rd_req_ready(req_ready[0]),
      .mem_rd_rsp_valid(rsp_valid[0]), .mem_rd_rsp_data(rsp_data[0]), .mem_rd_rsp_last(rsp_last[0]),
      .mem_rd_rsp_ready(rsp_ready[0]),
      .init_wen(init_wen[0]), .init_addr(init_addr[0]), .init_data(init_data[0])
   );

   burst_mem_responder #(.MEM_WORDS(4096), .LATENCY(0)) u_dut_l0 (
      .clk(clk), .rst(rst[1]),
      .mem_rd_req_valid(req_valid[1]), .mem_rd_req_addr(req_addr[1]), .mem_rd_req_ready(req_ready[1]),
      .mem_rd_rsp_valid(rsp_valid[1]), .mem_rd_rsp_data(rsp_data[1]), .mem_rd_rsp_last(rsp_last[1]),
      .mem_rd_rsp_ready(rsp_ready[1]),
      .init_wen(init_wen[1]), .init_addr(init_addr[1]), .init_data(init_data[1])
   );

   function automatic int lat_of(input int l);
      return (l == 0) ? 4 : 0;
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) % MEMW);
   endfunction

   function automatic int sb_size(input int l);
      return (l == 0) ? exp0_q.size() : exp1_q.size();
   endfunction

   function automatic logic [32:0] sb_front(input int l);
      return (l == 0) ? exp0_q[0] : exp1_q[0];
   endfunction

   task automatic sb_push(input int l, input logic [32:0] v);
      if (l == 0) exp0_q.push_back(v); else exp1_q.push_back(v);
   endtask

   task automatic sb_pop(input int l);
      if (l == 0) void'(exp0_q.pop_front()); else void'(exp1_q.pop_front());
   endtask

   task automatic sb_clear(input int l);
      if (l == 0) exp0_q.delete(); else exp1_q.delete();
   endtask

   task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s lane%0d t=%0t: got %h expected %h", nm, l, $time, act, exp);
      end
   endtask

   // Monitor + reference model: one outstanding line per lane, beats drained in order.
   always @(negedge clk) begin : mon
      bit          idle_now;
      bit          exp_valid;
      logic [32:0] f;
      int          base;
      if (done) begin
         chk("stim_timeouts", 0, tmo_cnt, 0);
         for (int l = 0; l < 2; l++) chk("leftover_beats", l, sb_size(l), 0);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
         $finish;
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (rst[l]) begin
               sb_clear(l);
               m_busy[l] = 1'b0;
               m_wait[l] = 0;
            end else begin
               idle_now  = !m_busy[l];
               exp_valid = m_busy[l] && (m_wait[l] == 0);
               chk("req_ready", l, 32'(req_ready[l]), 32'(idle_now));
               chk("rsp_valid", l, 32'(rsp_valid[l]), 32'(exp_valid));
               if (exp_valid && sb_size(l) > 0) begin
                  f = sb_front(l);
                  chk("rsp_data", l, rsp_data[l], f[31:0]);
                  chk("rsp_last", l, 32'(rsp_last[l]), 32'(f[32]));
                  if (rsp_ready[l]) begin
                     sb_pop(l);
                     if (f[32]) m_busy[l] = 1'b0;
                  end
               end else if (!exp_valid) begin
                  chk("idle_data", l, rsp_data[l], 32'h0);
                  chk("idle_last", l, 32'(rsp_last[l]), 32'h0);
                  if (m_busy[l]) m_wait[l]--;
               end
               if (idle_now && init_wen[l])
                  model_mem[l][word_of(init_addr[l])] = init_data[l];
               if (idle_now && req_valid[l]) begin
                  base = word_of(req_addr[l]) & ~7;
                  for (int b = 0; b < 8; b++) sb_push(l, {(b == 7), model_mem[l][base + b]});
                  m_busy[l] = 1'b1;
                  m_wait[l] = lat_of(l);
               end
            end
         end
      end
   end

   task automatic preload(input int l, input int w, input logic [31:0] d);
      logic [31:0] a;
      a       = $urandom;
      a[13:2] = 12'(w);
      init_wen[l]  = 1'b1;
      init_addr[l] = a;
      init_data[l] = d;
      @(posedge clk); #1;
      init_wen[l] = 1'b0;
   endtask

   // Issue one request and drain its beats; optional writes, reset and chained request.
   task automatic burst(input int l, input logic [31:0] addr, input int mode, input bit wr_during,
                        input bit wr_with_req, input int rst_at, input bit chain,
                        input logic [31:0] next_addr);
      bit ok;
      int hs;
      ok = 1'b0;
      req_valid[l] = 1'b1;
      req_addr[l]  = addr;
      for (int n = 0; n < 100; n++) begin
         if (wr_with_req) begin
            init_wen[l]  = 1'b1;
            init_addr[l] = {addr[31:5], 3'(n), 2'b00};
            init_data[l] = $urandom;
         end
         @(negedge clk);
         if (req_ready[l]) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      init_wen[l] = 1'b0;
      if (chain && ok) begin
         req_addr[l] = next_addr;
      end else begin
         req_valid[l] = 1'b0;
         req_addr[l]  = $urandom;
      end
      if (!ok) begin
         $display("FAIL req_accept lane%0d: got no acceptance expected acceptance within 100 cycles", l);
         tmo_cnt++;
         return;
      end
      hs = 0;
      for (int k = 0; k < 400 && hs < 8; k++) begin
         if (rst_at >= 0 && hs == rst_at && rsp_valid[l]) begin
            rst[l] = 1'b1;
            @(posedge clk); #1;
            rst[l]       = 1'b0;
            rsp_ready[l] = 1'b0;
            return;
         end
         case (mode)
            0:       rsp_ready[l] = 1'b1;
            1:       rsp_ready[l] = (k % 3 == 0);
            default: rsp_ready[l] = 1'($urandom_range(0, 1));
         endcase
         if (wr_during) begin
            init_wen[l]  = 1'b1;
            init_addr[l] = {addr[31:5], 3'($urandom), 2'b00};
            init_data[l] = $urandom;
         end
         @(negedge clk);
         if (rsp_valid[l] && rsp_ready[l]) hs++;
         @(posedge clk); #1;
      end
      init_wen[l]  = 1'b0;
      rsp_ready[l] = 1'b0;
      if (hs < 8) begin
         $display("FAIL beat_count lane%0d: got %0d handshakes expected 8", l, hs);
         tmo_cnt++;
      end
   endtask

   initial begin
      logic [31:0] a;
      int          l;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b0;
         init_wen[i] = 1'b0; init_addr[i] = '0; init_data[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 2; i++)
         for (int w = 0; w < 512; w++) preload(i, w, $urandom);
      for (int i = 0; i < 2; i++)
         for (int w = 0; w < 8; w++) preload(i, 'h40 + w, 32'hA0 + 32'(w));

      // LATENCY 4: basic, stalled, aliasing, reset mid-burst, ignored and accepted writes
      burst(0, 32'h104, 0, 0, 0, -1, 0, 0);
      burst(0, 32'h104, 1, 0, 0, -1, 0, 0);
      burst(0, 32'h4000, 0, 0, 0, -1, 0, 0);
      burst(0, 32'h0, 2, 0, 0, -1, 0, 0);
      burst(0, 32'h100, 0, 0, 0, 3, 0, 0);
      burst(0, 32'h100, 0, 0, 0, -1, 0, 0);
      burst(0, 32'h100, 2, 1, 0, -1, 0, 0);
      preload(0, 'h40, 32'h5555_0000);
      preload(0, 'h47, 32'h5555_0007);
      burst(0, 32'h11F, 0, 0, 0, -1, 0, 0);
      burst(0, 32'h100, 0, 0, 1, -1, 0, 0);

      // LATENCY 0: back-to-back with second request held during first burst
      burst(1, 32'h0, 0, 0, 0, -1, 1, 32'h20);
      burst(1, 32'h20, 0, 0, 0, -1, 0, 0);
      burst(1, 32'h104, 1, 0, 0, 3, 0, 0);
      burst(1, 32'h104, 1, 1, 0, -1, 0, 0);

      for (int i = 0; i < 40; i++) begin
         l = i % 2;
         a = $urandom;
         a[13:11] = 3'b000;
         burst(l, a, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1, 0, 0);
      end

      repeat (3) @(posedge clk);
      #1;
      done = 1'b1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before 100000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
